// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if : valid/ready data-memory bus between the LSU and memory
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_be;
  logic [63:0] bus_wdata;
  logic        bus_ready;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : multi-cycle memory-stage access engine with stall/timeout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        MemReadEnM,
  input  wire logic        MemWriteEnM,
  input  wire logic [1:0]  MemSizeM,
  input  wire logic        LoadUnsignedM,
  input  wire logic [63:0] ALUResultM,
  input  wire logic [63:0] ReadData2M,
  output logic             StallM,
  output logic [63:0]      ReadDataM,
  output logic             LoadDoneM,
  output logic             MisalignM,
  output logic             BusErrM,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  off_q, off_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;

  logic        access;
  logic        aligned;
  logic [7:0]  size_mask;
  logic [63:0] rd_shift;
  logic [63:0] rd_ext;
  logic        timeout_hit;

  always_comb begin
    // Inputs are ignored while reset is held so no stall/misalign leaks out.
    access = (MemReadEnM | MemWriteEnM) & ~rst;

    aligned   = 1'b1;
    size_mask = 8'h01;
    case (MemSizeM)
      2'b00: begin aligned = 1'b1;                     size_mask = 8'h01; end
      2'b01: begin aligned = ~ALUResultM[0];           size_mask = 8'h03; end
      2'b10: begin aligned = (ALUResultM[1:0] == 2'b00); size_mask = 8'h0F; end
      default: begin aligned = (ALUResultM[2:0] == 3'b000); size_mask = 8'hFF; end
    endcase

    rd_shift = bus.bus_rdata >> {off_q, 3'b000};
    rd_ext   = rd_shift;
    case (size_q)
      2'b00: rd_ext = uns_q ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
      2'b01: rd_ext = uns_q ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'b10: rd_ext = uns_q ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase

    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          state_d = REQ;
          cnt_d   = 32'd0;
          err_d   = 1'b0;
          addr_d  = {ALUResultM[63:3], 3'b000};
          we_d    = MemWriteEnM;
          be_d    = size_mask << ALUResultM[2:0];
          wdata_d = ReadData2M << {ALUResultM[2:0], 3'b000};
          size_d  = MemSizeM;
          uns_d   = LoadUnsignedM;
          off_d   = ALUResultM[2:0];
        end
      end
      REQ: begin
        if (bus.bus_ready) begin
          state_d = DONE;
          cnt_d   = 32'd0;
          if (!we_q) rdata_d = rd_ext;
        end else if (timeout_hit) begin
          state_d = DONE;
          cnt_d   = 32'd0;
          err_d   = 1'b1;
          rdata_d = 64'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      addr_q  <= 64'd0;
      we_q    <= 1'b0;
      be_q    <= 8'd0;
      wdata_q <= 64'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= 3'd0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  assign StallM    = ((state_q == IDLE) && access && aligned) || (state_q == REQ);
  assign MisalignM = (state_q == IDLE) && access && !aligned;
  assign LoadDoneM = (state_q == DONE) && !we_q && !err_q;
  assign BusErrM   = (state_q == DONE) && err_q;
  assign ReadDataM = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
  logic        clk;
  logic        rst;
  logic        MemReadEnM;
  logic        MemWriteEnM;
  logic [1:0]  MemSizeM;
  logic        LoadUnsignedM;
  logic [63:0] ALUResultM;
  logic [63:0] ReadData2M;
  logic        StallM;
  logic [63:0] ReadDataM;
  logic        LoadDoneM;
  logic        MisalignM;
  logic        BusErrM;

  int vectors;
  int miscompares;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .MemReadEnM    (MemReadEnM),
    .MemWriteEnM   (MemWriteEnM),
    .MemSizeM      (MemSizeM),
    .LoadUnsignedM (LoadUnsignedM),
    .ALUResultM    (ALUResultM),
    .ReadData2M    (ReadData2M),
    .StallM        (StallM),
    .ReadDataM     (ReadDataM),
    .LoadDoneM     (LoadDoneM),
    .MisalignM     (MisalignM),
    .BusErrM       (BusErrM),
    .bus           (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadEnM    = 1'b0;
    MemWriteEnM   = 1'b0;
    MemSizeM      = 2'b00;
    LoadUnsignedM = 1'b0;
    ALUResultM    = 64'd0;
    ReadData2M    = 64'd0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    idle_inputs();
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 64'd0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_stall",  {63'd0, StallM},         64'd0);
    chk("rst_req",    {63'd0, bus_if.bus_req}, 64'd0);
    chk("rst_rdata",  ReadDataM,               64'd0);
    chk("rst_be",     {56'd0, bus_if.bus_be},  64'd0);
    chk("rst_done",   {63'd0, LoadDoneM},      64'd0);

    // Zero-wait signed byte load
    cyc();
    MemReadEnM = 1'b1; MemSizeM = 2'b00; ALUResultM = 64'h1003;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h0000_0000_8000_0000;
    #1;
    chk("lb_accept_stall", {63'd0, StallM}, 64'd1);
    chk("lb_accept_req",   {63'd0, bus_if.bus_req}, 64'd0);
    cyc();
    chk("lb_req",      {63'd0, bus_if.bus_req}, 64'd1);
    chk("lb_be",       {56'd0, bus_if.bus_be},  64'h08);
    chk("lb_addr",     bus_if.bus_addr,         64'h1000);
    chk("lb_we",       {63'd0, bus_if.bus_we},  64'd0);
    chk("lb_req_stall",{63'd0, StallM},         64'd1);
    cyc();
    chk("lb_done_stall", {63'd0, StallM},    64'd0);
    chk("lb_data",       ReadDataM,          64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_loaddone",   {63'd0, LoadDoneM}, 64'd1);
    chk("lb_done_req",   {63'd0, bus_if.bus_req}, 64'd0);
    idle_inputs(); bus_if.bus_ready = 1'b0;
    cyc();
    chk("lb_idle_loaddone", {63'd0, LoadDoneM}, 64'd0);

    // Store half with three wait states
    MemWriteEnM = 1'b1; MemSizeM = 2'b01; ALUResultM = 64'h2006; ReadData2M = 64'hABCD;
    #1;
    chk("sh_accept_stall", {63'd0, StallM}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("sh_req",   {63'd0, bus_if.bus_req}, 64'd1);
      chk("sh_be",    {56'd0, bus_if.bus_be},  64'hC0);
      chk("sh_wdata", bus_if.bus_wdata,        64'hABCD_0000_0000_0000);
      chk("sh_addr",  bus_if.bus_addr,         64'h2000);
      chk("sh_we",    {63'd0, bus_if.bus_we},  64'd1);
      chk("sh_stall", {63'd0, StallM},         64'd1);
      if (k == 3) bus_if.bus_ready = 1'b1;
    end
    cyc();
    chk("sh_done_req",   {63'd0, bus_if.bus_req}, 64'd0);
    chk("sh_done_stall", {63'd0, StallM},         64'd0);
    chk("sh_no_loaddone",{63'd0, LoadDoneM},      64'd0);
    idle_inputs(); bus_if.bus_ready = 1'b0;

    // Unsigned then signed word load of the same data
    cyc();
    MemReadEnM = 1'b1; MemSizeM = 2'b10; ALUResultM = 64'h10; LoadUnsignedM = 1'b1;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h1234_5678_F000_0001;
    cyc();
    chk("lwu_be", {56'd0, bus_if.bus_be}, 64'h0F);
    cyc();
    chk("lwu_data", ReadDataM, 64'h0000_0000_F000_0001);
    chk("lwu_done", {63'd0, LoadDoneM}, 64'd1);
    idle_inputs(); bus_if.bus_ready = 1'b0;
    cyc();
    MemReadEnM = 1'b1; MemSizeM = 2'b10; ALUResultM = 64'h10; LoadUnsignedM = 1'b0;
    bus_if.bus_ready = 1'b1;
    cyc();
    cyc();
    chk("lw_data", ReadDataM, 64'hFFFF_FFFF_F000_0001);
    idle_inputs(); bus_if.bus_ready = 1'b0;
    cyc();
    chk("lw_hold", ReadDataM, 64'hFFFF_FFFF_F000_0001);

    // Misaligned double
    MemReadEnM = 1'b1; MemSizeM = 2'b11; ALUResultM = 64'h3004;
    #1;
    chk("mis_pulse", {63'd0, MisalignM},      64'd1);
    chk("mis_stall", {63'd0, StallM},         64'd0);
    chk("mis_req",   {63'd0, bus_if.bus_req}, 64'd0);
    cyc();
    idle_inputs();
    #1;
    chk("mis_after_req",   {63'd0, bus_if.bus_req}, 64'd0);
    chk("mis_after_pulse", {63'd0, MisalignM},      64'd0);

    // Timeout on a word load
    MemReadEnM = 1'b1; MemSizeM = 2'b10; ALUResultM = 64'h40;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("to_req", {63'd0, bus_if.bus_req}, 64'd1);
    end
    cyc();
    chk("to_req_low",  {63'd0, bus_if.bus_req}, 64'd0);
    chk("to_buserr",   {63'd0, BusErrM},        64'd1);
    chk("to_rdata",    ReadDataM,               64'd0);
    chk("to_loaddone", {63'd0, LoadDoneM},      64'd0);
    chk("to_stall",    {63'd0, StallM},         64'd0);
    idle_inputs();
    cyc();
    chk("to_idle_buserr", {63'd0, BusErrM}, 64'd0);
    chk("to_idle_req",    {63'd0, bus_if.bus_req}, 64'd0);

    // Reset in the second REQ cycle
    MemReadEnM = 1'b1; MemSizeM = 2'b11; ALUResultM = 64'h50;
    cyc();
    chk("rr_req1", {63'd0, bus_if.bus_req}, 64'd1);
    cyc();
    chk("rr_req2", {63'd0, bus_if.bus_req}, 64'd1);
    rst = 1'b1;
    idle_inputs();
    cyc();
    chk("rr_req_low", {63'd0, bus_if.bus_req}, 64'd0);
    chk("rr_stall",   {63'd0, StallM},         64'd0);
    chk("rr_loaddone",{63'd0, LoadDoneM},      64'd0);
    chk("rr_buserr",  {63'd0, BusErrM},        64'd0);
    rst = 1'b0;

    // Back-to-back load then store
    cyc();
    MemReadEnM = 1'b1; MemSizeM = 2'b11; ALUResultM = 64'h60;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h1122_3344_5566_7788;
    cyc();
    chk("bb_ld_req", {63'd0, bus_if.bus_req}, 64'd1);
    cyc();
    chk("bb_ld_data", ReadDataM, 64'h1122_3344_5566_7788);
    chk("bb_ld_done", {63'd0, LoadDoneM}, 64'd1);
    MemReadEnM = 1'b0; MemWriteEnM = 1'b1; MemSizeM = 2'b11;
    ALUResultM = 64'h68; ReadData2M = 64'hDEAD;
    bus_if.bus_ready = 1'b0;
    #1;
    chk("bb_done_stall", {63'd0, StallM}, 64'd0);
    cyc();
    chk("bb_accept_stall", {63'd0, StallM},         64'd1);
    chk("bb_accept_req",   {63'd0, bus_if.bus_req}, 64'd0);
    cyc();
    chk("bb_st_req",   {63'd0, bus_if.bus_req}, 64'd1);
    chk("bb_st_be",    {56'd0, bus_if.bus_be},  64'hFF);
    chk("bb_st_addr",  bus_if.bus_addr,         64'h68);
    chk("bb_st_wdata", bus_if.bus_wdata,        64'hDEAD);
    bus_if.bus_ready = 1'b1;
    cyc();
    chk("bb_st_done_req", {63'd0, bus_if.bus_req}, 64'd0);
    chk("bb_st_no_loaddone", {63'd0, LoadDoneM}, 64'd0);
    chk("bb_st_rdata_hold", ReadDataM, 64'h1122_3344_5566_7788);
    idle_inputs(); bus_if.bus_ready = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access engine for the memory stage of the RV64 pipelined processor.
- Consumes the memory-stage control and data bundle: read/write enables, size, unsigned flag, ALU address, store data.
- Drives a variable-latency valid/ready memory bus and returns sign/zero-extended load data to the memory→writeback pipeline register.
- Holds the pipeline with StallM while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, maximum REQ-state cycles waiting for bus_ready before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- MemReadEnM  in  1  load request from memory stage
- MemWriteEnM  in  1  store request from memory stage
- MemSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- LoadUnsignedM  in  1  1 = zero-extend load (lbu/lhu/lwu); ignored for double and stores
- ALUResultM  in  64  effective byte address
- ReadData2M  in  64  store data, right-aligned
- StallM  out  1  freeze PC and IF/ID, ID/EX, EX/MEM registers
- ReadDataM  out  64  extended load result
- LoadDoneM  out  1  one-cycle pulse: ReadDataM valid for a completed load
- MisalignM  out  1  one-cycle pulse: misaligned access was dropped
- BusErrM  out  1  one-cycle pulse: bus timeout
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  64  doubleword-aligned address, {ALUResultM[63:3],3'b000}
- bus_be  out  8  byte enables
- bus_wdata  out  64  lane-aligned write data
- bus_ready  in  1  completion strobe from memory
- bus_rdata  in  64  read data, valid when bus_ready=1

Behaviour:
- Reset values: state IDLE, timeout counter 0, every output 0.
- Reset mid-transaction: bus_req drops at that edge, the access is abandoned, and no pulse is issued.
- States: IDLE, REQ, DONE.
- Access definition: access = MemReadEnM | MemWriteEnM. Both asserted means a store; the read is ignored.
- Alignment: aligned when ALUResultM[2:0] is a multiple of the size (half: bit0=0; word: [1:0]=0; double: [2:0]=0).

IDLE:
- No access: stay in IDLE, StallM=0.
- Access, misaligned: MisalignM=1 for that cycle, StallM=0, no bus activity, stay in IDLE.
- Access, aligned: StallM=1 (combinational); register addr/we/be/wdata/size/unsigned; next state REQ.

REQ:
- bus_req=1 and StallM=1. bus_addr, bus_we, bus_be and bus_wdata are held stable from registers.
- The transfer completes on the edge where bus_ready=1. On a load, latch the extended data into ReadDataM; next state DONE.
- The counter increments each REQ cycle without bus_ready. When count == TIMEOUT_CYCLES-1 with no ready (TIMEOUT_CYCLES>0): drop bus_req, set BusErrM=1, ReadDataM=0, next state DONE.

DONE:
- StallM=0; LoadDoneM=1 if the access was a load and did not error; BusErrM pulses here on timeout.
- Always returns to IDLE, ignoring inputs. The stalled instruction leaves the memory stage at this edge.

Lane and extension rules:
- Lane: off = ALUResultM[2:0]. bus_be = {1,3,15,255}[size] << off. bus_wdata = ReadData2M << (8*off).
- Load: raw = bus_rdata >> (8*off), then truncate to the access size.
- Extension: sign-extend from bit 7/15/31 unless LoadUnsignedM. Doubles are used as-is.
- ReadDataM holds its value until the next load completes or errors.

Latency and throughput:
- Minimum access: 3 cycles (IDLE accept, REQ with ready, DONE).
- Back-to-back accesses: the second is accepted in the IDLE cycle after DONE.

Test Plan:
- Zero-wait load byte: addr 0x1003, MemSizeM=00, signed, bus_ready=1 immediately, bus_rdata=0x0000_0000_8000_0000 → bus_be=0x08, StallM high exactly 2 cycles, DONE cycle ReadDataM=0xFFFF_FFFF_FFFF_FF80, LoadDoneM pulse.
- Store half with 3 wait states: addr 0x2006, data 0xABCD → bus_be=0xC0, bus_wdata=0xABCD_0000_0000_0000, bus_req held 4 cycles with stable fields, StallM 5 cycles, no LoadDoneM.
- Unsigned word load: addr 0x10, LoadUnsignedM=1, bus_rdata=0x1234_5678_F000_0001 → ReadDataM=0x0000_0000_F000_0001. The same access with LoadUnsignedM=0 → 0xFFFF_FFFF_F000_0001.
- Misaligned double: addr 0x3004 → MisalignM single pulse, bus_req never asserted, StallM stays 0.
- Timeout: TIMEOUT_CYCLES=4, bus_ready held 0 → bus_req high 4 cycles then low, BusErrM pulse in DONE, ReadDataM=0, state returns to IDLE.
- Reset during REQ, then back-to-back accesses: rst asserted in the 2nd REQ cycle → bus_req=0 and StallM=0 after that edge, no pulses. After rst releases, a load immediately followed by a store → second bus_req rises exactly 2 cycles after the first completes.
